// File: rtl/log_mult_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : log_mult_pipe
//  Description : Two-stage pipelined Mitchell logarithmic multiplier.
//                The operands arrive already split into a leading-one
//                position (characteristic k) and a normalised fraction (m1,
//                hidden one removed). S1 adds the two logarithms and S2 takes
//                the approximate antilog. A valid/ready handshake on both
//                sides lets the pipeline stall without losing data.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    NUM_LENGTH : operand width (product is 2*NUM_LENGTH bits)
//    K_LENGTH   : characteristic width, log2(NUM_LENGTH)
//    M1_LENGTH  : normalised fraction width
//  Ports
//    clk        : clock, all state on the rising edge
//    rst_n      : asynchronous active-low reset
//    in_valid   : operand pair valid
//    in_ready   : operand pair accepted this cycle (combinational)
//    k_a, k_b   : leading-one position of A / B
//    m1_a, m1_b : normalised fraction of A / B
//    zero_a/_b  : operand A / B is zero (k and m1 are then ignored)
//    out_valid  : product valid
//    out_ready  : downstream accepts product
//    product    : Mitchell approximate product
//    op_count   : completed results, saturating at 0xFFFF
// ============================================================================
module log_mult_pipe #(
    parameter int NUM_LENGTH = 32,
    parameter int K_LENGTH   = 5,
    parameter int M1_LENGTH  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [K_LENGTH-1:0]       k_a,
    input  logic [K_LENGTH-1:0]       k_b,
    input  logic [M1_LENGTH-1:0]      m1_a,
    input  logic [M1_LENGTH-1:0]      m1_b,
    input  logic                      zero_a,
    input  logic                      zero_b,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [2*NUM_LENGTH-1:0]   product,
    output logic [15:0]               op_count
);

    // ------------------------------------------------------------------
    // Derived widths
    // ------------------------------------------------------------------
    localparam int c_PROD_W = 2 * NUM_LENGTH;
    // The antilog shift is done with M1_LENGTH extra fraction bits kept
    // below the binary point; they are dropped afterwards (truncation).
    localparam int c_EXT_W  = c_PROD_W + M1_LENGTH;
    localparam int c_KS_W   = K_LENGTH + 1;
    localparam int c_S_W    = M1_LENGTH + 1;
    localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

    // ------------------------------------------------------------------
    // Pipeline state
    // ------------------------------------------------------------------
    logic                  r_s1_valid;
    logic [c_KS_W-1:0]     r_s1_k;      // k_a + k_b
    logic [c_S_W-1:0]      r_s1_s;      // m1_a + m1_b, with carry bit
    logic                  r_s1_z;      // either operand zero

    logic                  r_s2_valid;
    logic [c_PROD_W-1:0]   r_product;

    logic [15:0]           r_op_count;

    // ------------------------------------------------------------------
    // Handshake / advance conditions
    // ------------------------------------------------------------------
    logic w_s2_adv;
    logic w_s1_adv;
    logic w_in_fire;
    logic w_out_fire;

    // A stage may take new content when it is empty or when its current
    // content leaves this cycle. Because S1 looks through to S2, a full
    // pipeline still accepts an input in the same cycle an output leaves.
    assign w_s2_adv   = !r_s2_valid || out_ready;
    assign w_s1_adv   = !r_s1_valid || w_s2_adv;
    assign w_in_fire  = in_valid && w_s1_adv;
    assign w_out_fire = r_s2_valid && out_ready;

    // ------------------------------------------------------------------
    // S1 combinational: log-domain addition
    // ------------------------------------------------------------------
    logic [c_KS_W-1:0] w_k_sum;
    logic [c_S_W-1:0]  w_m_sum;
    logic              w_z;

    assign w_k_sum = {1'b0, k_a} + {1'b0, k_b};
    assign w_m_sum = {1'b0, m1_a} + {1'b0, m1_b};
    assign w_z     = zero_a || zero_b;

    // ------------------------------------------------------------------
    // S2 combinational: carry correction and antilog
    // ------------------------------------------------------------------
    logic                  w_carry;
    logic [c_KS_W-1:0]     w_k_corr;
    logic [M1_LENGTH-1:0]  w_frac;
    logic [c_EXT_W-1:0]    w_mant_ext;
    logic [c_EXT_W-1:0]    w_shifted;
    logic [c_PROD_W-1:0]   w_antilog;
    logic [c_PROD_W-1:0]   w_product_next;

    // A fraction sum of 1.0 or more moves one into the characteristic;
    // the remaining fraction is just the low bits in both cases, since
    // without a carry the top bit of the sum is already zero.
    assign w_carry    = r_s1_s[M1_LENGTH];
    assign w_k_corr   = r_s1_k + c_KS_W'(w_carry);
    assign w_frac     = r_s1_s[M1_LENGTH-1:0];

    // With K_LENGTH = log2(NUM_LENGTH) the corrected characteristic is at
    // most 2*NUM_LENGTH-1, so the hidden one lands at or below the top
    // bit of the extended word and the product cannot overflow.
    assign w_mant_ext = c_EXT_W'({1'b1, w_frac});
    assign w_shifted  = w_mant_ext << w_k_corr;
    assign w_antilog  = w_shifted[c_EXT_W-1:M1_LENGTH];

    assign w_product_next = r_s1_z ? '0 : w_antilog;

    // ------------------------------------------------------------------
    // S1 registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_k     <= '0;
            r_s1_s     <= '0;
            r_s1_z     <= 1'b0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            // Data only moves on a real transfer; an idle slot keeps the
            // old data and is marked empty by the valid bit alone.
            if (in_valid) begin
                r_s1_k <= w_k_sum;
                r_s1_s <= w_m_sum;
                r_s1_z <= w_z;
            end
        end
    end

    // ------------------------------------------------------------------
    // S2 registers (output stage)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_product  <= '0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_product <= w_product_next;
            end
        end
    end

    // ------------------------------------------------------------------
    // Completed-result counter, sticks at all-ones
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_count <= '0;
        end else if (w_out_fire && (r_op_count != c_CNT_MAX)) begin
            r_op_count <= r_op_count + 16'd1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready  = w_s1_adv;
    assign out_valid = r_s2_valid;
    assign product   = r_product;
    assign op_count  = r_op_count;

    // w_in_fire is kept for readability of the handshake; it is not
    // otherwise needed because S1 already gates on in_valid.
    logic w_unused;
    assign w_unused = w_in_fire;

endmodule
`default_nettype wire

// File: doc/log_mult_pipe.md
LOG_MULT_PIPE -- requirements
Module: log_mult_pipe

Interface
REQ-001 The module SHALL have parameter NUM_LENGTH, default 32, giving the operand width.
REQ-002 The module SHALL have parameter K_LENGTH, default 5, giving the characteristic width (log2 of NUM_LENGTH).
REQ-003 The module SHALL have parameter M1_LENGTH, default 16, giving the normalised mantissa fraction width, with the hidden one removed.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 The module SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The module SHALL have port in_valid, input, 1 bit: the operand pair is valid.
REQ-007 The module SHALL have port in_ready, output, 1 bit: the block accepts the operand pair this cycle.
REQ-008 The module SHALL have ports k_a and k_b, input, K_LENGTH bits each: the leading-one position of operands A and B.
REQ-009 The module SHALL have ports m1_a and m1_b, input, M1_LENGTH bits each: the normalised fraction of operands A and B.
REQ-010 The module SHALL have ports zero_a and zero_b, input, 1 bit each: operand A or B equals 0, and its k and m1 are don't-care.
REQ-011 The module SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-012 The module SHALL have port out_ready, input, 1 bit: the downstream accepts the result.
REQ-013 The module SHALL have port product, output, 2*NUM_LENGTH bits: the Mitchell approximate product.
REQ-014 The module SHALL have port op_count, output, 16 bits: the number of completed results, saturating.

Function
REQ-015 The module SHALL transfer an input when in_valid and in_ready are both high in the same cycle.
REQ-016 The module SHALL transfer an output when out_valid and out_ready are both high in the same cycle.
REQ-017 The module SHALL form a 2-stage pipeline: S1 (log add) and S2 (antilog), each with its own valid bit.
REQ-018 The block SHALL have a latency of 2 cycles from input transfer to out_valid when there is no stall.
REQ-019 The block SHALL sustain a throughput of 1 transfer per cycle while out_ready is held high.
REQ-020 S2 SHALL advance when s2_valid is low or out_ready is high.
REQ-021 S1 SHALL advance when s1_valid is low or S2 advances.
REQ-022 in_ready SHALL equal the S1 advance condition, and SHALL be combinational with no dependency on in_valid.
REQ-023 S1 SHALL register K = k_a + k_b, computed at K_LENGTH+1 bits with no overflow.
REQ-024 S1 SHALL register S = m1_a + m1_b, computed at M1_LENGTH+1 bits.
REQ-025 S1 SHALL register z = zero_a OR zero_b.
REQ-026 S2 SHALL apply carry correction: if S[M1_LENGTH] = 1, then K' = K + 1 and f = S[M1_LENGTH-1:0]; otherwise K' = K and f = S.
REQ-027 S2 SHALL compute product = ({1'b1, f} << K') >> M1_LENGTH, with the intermediate at 2*NUM_LENGTH+M1_LENGTH bits and the low bits truncated (no rounding).
REQ-028 K' SHALL NOT exceed 2*NUM_LENGTH-1, so the product never overflows 2*NUM_LENGTH bits.
REQ-029 When z = 1, S2 SHALL output product = 0 regardless of K and S.
REQ-030 A stage whose valid bit is low SHALL NOT update its data registers.
REQ-031 While out_valid is high and out_ready is low, product SHALL be held stable.
REQ-032 During a stall, S1 SHALL retain its content, and a pending out_valid SHALL NOT drop.
REQ-033 On a full pipeline with out_ready low, in_ready SHALL be 0.
REQ-034 On a full pipeline, an output transfer and an input transfer in the same cycle SHALL both complete, with no bubble and no data loss.
REQ-035 op_count SHALL increment by 1 on each output transfer, and SHALL saturate at 0xFFFF without wrapping.

Reset
REQ-036 While rst_n is low, s1_valid, s2_valid, out_valid, product and op_count SHALL all be 0.
REQ-037 While rst_n is low, in_ready SHALL be 1, since it is derived from the cleared valid bits.
REQ-038 An rst_n assertion mid-operation SHALL discard in-flight data immediately, asynchronously, and no result SHALL appear after release.
REQ-039 After rst_n deasserts, the first transfer SHALL be accepted on the first rising clk edge.

Verification
REQ-040 The bench SHALL check a=3, b=5: k_a=1, m1_a=0x8000, k_b=2, m1_b=0x4000 -> product=14 two cycles after acceptance, with op_count=1.
REQ-041 The bench SHALL check the carry case a=b=3: k=1, m1=0x8000 on both -> S=0x10000, K'=3, f=0 -> product=8.
REQ-042 The bench SHALL check the maximum case a=b=0xFFFFFFFF: k=31, m1=0xFFFF on both -> product=0xFFFF000000000000 with no overflow.
REQ-043 The bench SHALL check zero: zero_a=1, k_b=7, m1_b=0x1234 -> product=0.
REQ-044 The bench SHALL check backpressure: hold out_ready=0 and push 3 pairs -> exactly 2 are accepted, in_ready=0, and product is stable; then raise out_ready -> results exit in order with no loss or duplicate, and op_count=3.
REQ-045 The bench SHALL check reset mid-flight: pull rst_n low with 2 ops in flight -> out_valid=0 and op_count=0 immediately, and no stale result appears after release.
